updown_sequencer: RTL and testbench

//  Two-requester move controller for a 4-bit up/down counter (dir 01=up, 11=down, 00/10=hold).

---
 rtl/updown_sequencer.sv | 109 ++++++++++
 tb/tb_updown_sequencer.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/updown_sequencer.sv
// Two-requester move controller for an up/down counter: accepts targets round-robin
// and steers the counter along the shortest modular path, then reports done or timeout.
module updown_sequencer #(
   parameter int WIDTH   = 4,
   parameter int TIMEOUT = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [1:0]       req_valid,
   input  logic [WIDTH-1:0] req_target0,
   input  logic [WIDTH-1:0] req_target1,
   output logic [1:0]       req_ready,
   input  logic [WIDTH-1:0] count_in,
   output logic [1:0]       dir_out,
   output logic             busy,
   output logic             grant_id,
   output logic [1:0]       done,
   output logic             err,
   output logic [WIDTH-1:0] last_steps
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_MOVE  = 2'd1;
   localparam logic [1:0] S_DONE  = 2'd2;
   localparam logic [1:0] S_ABORT = 2'd3;

   localparam int TW = $clog2(TIMEOUT + 1);
   localparam logic [TW-1:0]    TIMEOUT_LAST = TW'(TIMEOUT - 1);
   localparam logic [WIDTH-1:0] HALF         = {1'b1, {(WIDTH-1){1'b0}}};
   localparam logic [WIDTH-1:0] STEPS_MAX    = '1;

   logic [1:0]       state;
   logic             rr_last;
   logic [WIDTH-1:0] target_q;
   logic [WIDTH-1:0] steps;
   logic [TW-1:0]    move_cnt;
   logic [WIDTH-1:0] diff;
   logic             prio;
   logic             accept;
   logic             accept_id;

   // Priority goes to whichever requester was not served last.
   always_comb begin
      req_ready = 2'b00;
      prio      = ~rr_last;
      if (state == S_IDLE) begin
         if (req_valid[prio])
            req_ready[prio] = 1'b1;
         else if (req_valid[~prio])
            req_ready[~prio] = 1'b1;
      end
      accept    = |(req_valid & req_ready);
      accept_id = req_ready[1];
   end

   // Direction depends on the live count so the move stops exactly on target;
   // a distance of exactly half the ring is taken upward.
   always_comb begin
      diff    = target_q - count_in;
      dir_out = 2'b00;
      if (state == S_MOVE && diff != '0)
         dir_out = (diff <= HALF) ? 2'b01 : 2'b11;
   end

   assign busy = (state != S_IDLE);
   assign done = (state == S_DONE) ? (grant_id ? 2'b10 : 2'b01) : 2'b00;
   assign err  = (state == S_ABORT);

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= S_IDLE;
         rr_last    <= 1'b1;
         target_q   <= '0;
         steps      <= '0;
         last_steps <= '0;
         grant_id   <= 1'b0;
         move_cnt   <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (accept) begin
                  target_q <= accept_id ? req_target1 : req_target0;
                  grant_id <= accept_id;
                  rr_last  <= accept_id;
                  steps    <= '0;
                  move_cnt <= '0;
                  state    <= S_MOVE;
               end
            end
            S_MOVE: begin
               if (dir_out != 2'b00 && steps != STEPS_MAX)
                  steps <= steps + 1'b1;
               if (diff == '0) begin
                  last_steps <= steps;
                  state      <= S_DONE;
               end else if (move_cnt == TIMEOUT_LAST) begin
                  state <= S_ABORT;
               end else begin
                  move_cnt <= move_cnt + 1'b1;
               end
            end
            S_DONE:  state <= S_IDLE;
            S_ABORT: state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_updown_sequencer.sv
// Self-checking bench for updown_sequencer: a behavioural counter closes the loop and a
// scoreboard of expected completions is checked whenever done or err fires.
module tb_updown_sequencer;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [1:0] req_valid = 2'b00;
   logic [3:0] req_target0 = 4'd0;
   logic [3:0] req_target1 = 4'd0;
   logic [1:0] req_ready;
   logic [3:0] count_in = 4'd0;
   logic [1:0] dir_out;
   logic       busy;
   logic       grant_id;
   logic [1:0] done;
   logic       err;
   logic [3:0] last_steps;

   logic       cnt_load = 1'b0;
   logic [3:0] cnt_val = 4'd0;

   typedef struct {
      logic       g;
      logic [3:0] tgt;
      logic [3:0] steps;
      logic       abort;
   } exp_t;

   exp_t sb[$];
   int checks = 0;
   int errors = 0;
   logic [3:0] model_last = 4'd0;

   updown_sequencer #(.WIDTH(4), .TIMEOUT(32)) dut (
      .clk(clk), .reset(reset), .req_valid(req_valid),
      .req_target0(req_target0), .req_target1(req_target1), .req_ready(req_ready),
      .count_in(count_in), .dir_out(dir_out), .busy(busy), .grant_id(grant_id),
      .done(done), .err(err), .last_steps(last_steps)
   );

   always #5 clk = ~clk;

   // Behavioural 4-bit counter driven by dir_out, with a bench-side load for disturbances.
   always @(posedge clk) begin
      if (cnt_load)
         count_in <= cnt_val;
      else if (dir_out == 2'b01)
         count_in <= count_in + 4'd1;
      else if (dir_out == 2'b11)
         count_in <= count_in - 4'd1;
   end

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic int distOf(input logic [3:0] t, input logic [3:0] c);
      logic [3:0] d;
      d = t - c;
      return (d <= 4'd8) ? int'(d) : 16 - int'(d);
   endfunction

   task automatic applyStimulus(input int id, input logic [3:0] tgt);
      if (id == 0) req_target0 = tgt;
      else         req_target1 = tgt;
      req_valid[id] = 1'b1;
   endtask

   task automatic loadCount(input logic [3:0] v);
      cnt_val  = v;
      cnt_load = 1'b1;
      @(posedge clk); #1;
      cnt_load = 1'b0;
   endtask

   // Waits for a handshake, records the expected outcome, and returns just after the accept edge.
   task automatic waitAccept(input bit expect_abort, output int gid);
      bit ok;
      exp_t e;
      ok  = 1'b0;
      gid = 0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if ((req_valid & req_ready) != 2'b00) begin
            ok = 1'b1;
            break;
         end
      end
      checkOutput("accept_seen", ok, 1);
      if (ok) begin
         gid     = req_ready[1] ? 1 : 0;
         e.g     = req_ready[1];
         e.tgt   = req_ready[1] ? req_target1 : req_target0;
         e.abort = expect_abort;
         if (expect_abort) begin
            e.steps = model_last;
         end else begin
            e.steps    = 4'(distOf(e.tgt, count_in));
            model_last = e.steps;
         end
         sb.push_back(e);
         @(posedge clk); #1;
         req_valid[gid] = 1'b0;
      end
   endtask

   task automatic waitIdle();
      for (int i = 0; i < 200; i++) begin
         @(posedge clk); #1;
         if (!busy) break;
      end
      checkOutput("idle_reached", busy, 0);
   endtask

   // Checks n cycles of direction d with the count walking from start, then hold and done.
   task automatic checkRun(input logic [1:0] d, input int n, input logic [3:0] start,
                           input logic [1:0] done_exp);
      logic [3:0] ec;
      ec = start;
      for (int i = 0; i < n; i++) begin
         checkOutput("run_dir", dir_out, d);
         checkOutput("run_count", count_in, ec);
         ec = (d == 2'b01) ? ec + 4'd1 : ec - 4'd1;
         @(posedge clk); #1;
      end
      checkOutput("run_hold", dir_out, 0);
      @(posedge clk); #1;
      checkOutput("done_latency", done, done_exp);
   endtask

   always @(negedge clk) begin : monitor
      exp_t e;
      if (!reset && (done != 2'b00 || err)) begin
         if (sb.size() == 0) begin
            checkOutput("spurious_done", {done, err}, 0);
         end else begin
            e = sb.pop_front();
            checkOutput("done", done, e.abort ? 0 : (e.g ? 2 : 1));
            checkOutput("err", err, e.abort);
            checkOutput("last_steps", last_steps, e.steps);
            checkOutput("grant_id", grant_id, e.g);
            if (!e.abort) checkOutput("final_count", count_in, e.tgt);
         end
      end
   end

   initial begin : watchdog
      #500000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int g;
      int k;
      cnt_load = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      reset    = 1'b0;
      cnt_load = 1'b0;
      checkOutput("rst_busy", busy, 0);
      checkOutput("rst_dir", dir_out, 0);
      checkOutput("rst_done", done, 0);
      checkOutput("rst_err", err, 0);
      checkOutput("rst_last_steps", last_steps, 0);
      checkOutput("rst_grant", grant_id, 0);

      $display("[TB] up move 0 -> 5");
      applyStimulus(0, 4'd5);
      waitAccept(1'b0, g);
      checkRun(2'b01, 5, 4'd0, 2'b01);
      waitIdle();

      $display("[TB] down move 2 -> 14 through wrap");
      loadCount(4'd2);
      applyStimulus(1, 4'd14);
      waitAccept(1'b0, g);
      checkRun(2'b11, 4, 4'd2, 2'b10);
      waitIdle();

      $display("[TB] tie move 0 -> 8");
      loadCount(4'd0);
      applyStimulus(0, 4'd8);
      waitAccept(1'b0, g);
      checkRun(2'b01, 8, 4'd0, 2'b01);
      waitIdle();

      $display("[TB] disturbed move 0 -> 7 times out");
      loadCount(4'd0);
      applyStimulus(0, 4'd7);
      waitAccept(1'b1, g);
      k = 0;
      while (k < 60 && !err) begin
         cnt_val  = 4'd0;
         cnt_load = (k % 3 == 2);
         @(posedge clk); #1;
         k++;
      end
      cnt_load = 1'b0;
      checkOutput("abort_cycle", k, 32);
      checkOutput("abort_no_done", done, 0);
      waitIdle();

      $display("[TB] move to current count");
      loadCount(4'd8);
      applyStimulus(1, 4'd8);
      waitAccept(1'b0, g);
      checkRun(2'b01, 0, 4'd8, 2'b10);
      waitIdle();

      $display("[TB] reset during move");
      loadCount(4'd0);
      applyStimulus(0, 4'd7);
      waitAccept(1'b0, g);
      repeat (3) begin
         @(posedge clk); #1;
      end
      reset = 1'b1;
      sb.delete();
      model_last = 4'd0;
      @(posedge clk); #1;
      reset = 1'b0;
      checkOutput("midrst_busy", busy, 0);
      checkOutput("midrst_dir", dir_out, 0);
      checkOutput("midrst_done", done, 0);
      checkOutput("midrst_last_steps", last_steps, 0);
      checkOutput("midrst_grant", grant_id, 0);

      $display("[TB] both requesters pending, round-robin");
      applyStimulus(0, 4'd6);
      applyStimulus(1, 4'd12);
      #1;
      checkOutput("rr_first_ready", req_ready, 2'b01);
      for (int i = 0; i < 4; i++) begin
         waitAccept(1'b0, g);
         checkOutput("rr_grant", g, i % 2);
         if (i < 2) applyStimulus(g, 4'd9);
         #1;
         checkOutput("rr_ready_busy", req_ready, 0);
      end
      waitIdle();

      repeat (2) @(posedge clk);
      checkOutput("sb_drained", sb.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
